// File: rtl/stim_gen.sv
// rtl/stim_gen.sv - operand stimulus generator with random, sweep, walking-one and corner patterns
//
// Produces one registered operand pair per cycle on o_ia/o_ib for a programmable
// number of vectors and reports progress (o_count, o_busy) and completion (o_done).
//
// Parameters:
//   WIDTH        operand width, 8..32
//   COUNT_WIDTH  width of the vector counter and of i_num_tests
//   SEED_A       LFSR seed for operand A (0 is replaced by 1)
//   SEED_B       LFSR seed for operand B (0 is replaced by 1)
//
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous active-high reset
//   i_start      begin a run (sampled in IDLE only)
//   i_stop       abort the current run; wins over i_start in IDLE
//   i_hold       pause generator, count and outputs
//   i_mode       00 random, 01 sweep, 10 walking-one, 11 corner
//   i_num_tests  vectors per run, 0 = free-run until i_stop
//   o_ia, o_ib   operand pair
//   o_valid      o_ia/o_ib carry a vector this cycle
//   o_busy       FSM is in RUN
//   o_done       one-cycle pulse at the end of a run
//   o_count      vectors issued in the current or last run
//
// Build option: define STIM_GEN_CORNER_EN to include the corner table; without it
// mode 11 behaves exactly as random mode.

module stim_gen #(
    parameter int          WIDTH       = 32,
    parameter int          COUNT_WIDTH = 32,
    parameter logic [31:0] SEED_A      = 32'h1,
    parameter logic [31:0] SEED_B      = 32'h2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_hold,
    input  logic [1:0]             i_mode,
    input  logic [COUNT_WIDTH-1:0] i_num_tests,
    output logic [WIDTH-1:0]       o_ia,
    output logic [WIDTH-1:0]       o_ib,
    output logic                   o_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [COUNT_WIDTH-1:0] o_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_RANDOM = 2'b00;
    localparam logic [1:0] MODE_SWEEP  = 2'b01;
    localparam logic [1:0] MODE_WALK   = 2'b10;
    localparam logic [1:0] MODE_CORNER = 2'b11;

    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'd0) ? 32'd1 : SEED_B;

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Galois LFSR step, shared by both operands.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'd0);
    endfunction

    // Mode actually used for a run; folds corner onto random when the table is absent.
    function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef STIM_GEN_CORNER_EN
        return m;
`else
        return (m == MODE_CORNER) ? MODE_RANDOM : m;
`endif
    endfunction

`ifdef STIM_GEN_CORNER_EN
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    // Corner table entry as {a, b}.
    function automatic logic [2*WIDTH-1:0] corner_entry(input logic [2:0] idx);
        logic [2*WIDTH-1:0] e;
        case (idx)
            3'd0:    e = {ZERO,     ZERO};
            3'd1:    e = {ZERO,     ALL_ONES};
            3'd2:    e = {ALL_ONES, ZERO};
            3'd3:    e = {ALL_ONES, ALL_ONES};
            3'd4:    e = {ONE,      ALL_ONES};
            3'd5:    e = {ALL_ONES, ONE};
            3'd6:    e = {MSB_ONLY, MSB_ONLY};
            default: e = {MSB_ONLY, ALL_ONES};
        endcase
        return e;
    endfunction

    logic [2:0] corner_idx_q;   // table index of the next vector to issue
`endif

    logic [1:0]             state_q;
    logic [1:0]             mode_q;
    logic [COUNT_WIDTH-1:0] num_q;
    // LFSR registers hold the state for the *next* random vector; vector 0 is the seed itself.
    logic [31:0]            lfsr_a_q;
    logic [31:0]            lfsr_b_q;

    logic [WIDTH-1:0]       first_a;
    logic [WIDTH-1:0]       first_b;
    logic [WIDTH-1:0]       next_a;
    logic [WIDTH-1:0]       next_b;
    logic [WIDTH-1:0]       walk_rot;
    logic                   last_vec;

    // Vector 0 of a run, selected from the mode being latched.
    always_comb begin
        first_a = ZERO;
        first_b = ZERO;
        case (eff_mode(i_mode))
            MODE_RANDOM: begin
                first_a = SEED_A_EFF[WIDTH-1:0];
                first_b = SEED_B_EFF[WIDTH-1:0];
            end
            MODE_WALK: begin
                first_a = ONE;
                first_b = ~ONE;
            end
`ifdef STIM_GEN_CORNER_EN
            MODE_CORNER: {first_a, first_b} = corner_entry(3'd0);
`endif
            default: begin
                first_a = ZERO;
                first_b = ZERO;
            end
        endcase
    end

    // Vector k+1 derived from the currently presented vector k and the pattern state.
    always_comb begin
        next_a   = o_ia;
        next_b   = o_ib;
        walk_rot = {o_ia[WIDTH-2:0], o_ia[WIDTH-1]};
        case (mode_q)
            MODE_RANDOM: begin
                next_a = lfsr_a_q[WIDTH-1:0];
                next_b = lfsr_b_q[WIDTH-1:0];
            end
            MODE_SWEEP: begin
                // B counts how many times A has wrapped.
                next_a = o_ia + ONE;
                next_b = o_ib + {{(WIDTH-1){1'b0}}, (o_ia == ALL_ONES)};
            end
            MODE_WALK: begin
                next_a = walk_rot;
                next_b = ~walk_rot;
            end
`ifdef STIM_GEN_CORNER_EN
            MODE_CORNER: {next_a, next_b} = corner_entry(corner_idx_q);
`endif
            default: begin
                next_a = o_ia;
                next_b = o_ib;
            end
        endcase
    end

    // A bounded run ends once its final vector has actually been presented unpaused.
    assign last_vec = o_valid && !i_hold && (num_q != '0) && (o_count == num_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_RANDOM;
            num_q        <= '0;
            lfsr_a_q     <= SEED_A_EFF;
            lfsr_b_q     <= SEED_B_EFF;
`ifdef STIM_GEN_CORNER_EN
            corner_idx_q <= 3'd0;
`endif
            o_ia         <= '0;
            o_ib         <= '0;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_count      <= '0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start && !i_stop) begin
                        state_q      <= ST_RUN;
                        mode_q       <= eff_mode(i_mode);
                        num_q        <= i_num_tests;
                        lfsr_a_q     <= lfsr_step(SEED_A_EFF);
                        lfsr_b_q     <= lfsr_step(SEED_B_EFF);
`ifdef STIM_GEN_CORNER_EN
                        corner_idx_q <= 3'd1;
`endif
                        o_ia         <= first_a;
                        o_ib         <= first_b;
                        o_valid      <= 1'b1;
                        o_busy       <= 1'b1;
                        o_count      <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    if (i_stop || last_vec) begin
                        state_q <= ST_DONE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else if (i_hold) begin
                        o_valid <= 1'b0;
                    end else if (!o_valid) begin
                        // First cycle after a hold: re-present the held vector without counting it.
                        o_valid <= 1'b1;
                    end else begin
                        o_ia     <= next_a;
                        o_ib     <= next_b;
                        lfsr_a_q <= lfsr_step(lfsr_a_q);
                        lfsr_b_q <= lfsr_step(lfsr_b_q);
`ifdef STIM_GEN_CORNER_EN
                        corner_idx_q <= corner_idx_q + 3'd1;
`endif
                        o_count  <= o_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_gen.sv
// tb/tb_stim_gen.sv - scoreboard bench for stim_gen at WIDTH 32 and WIDTH 8

module tb_stim_gen;

    typedef struct packed {
        logic [31:0] ia;
        logic [31:0] ib;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        hold;
    logic [1:0]  mode;
    logic [31:0] num;

    logic [31:0] ia32, ib32, cnt32;
    logic        valid32, busy32, done32;
    logic [7:0]  ia8, ib8;
    logic [31:0] cnt8;
    logic        valid8, busy8, done8;

    exp_t q32[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done32 = 0;
    int   n_done8 = 0;

    always #5 clk = ~clk;

    stim_gen #(.WIDTH(32), .COUNT_WIDTH(32), .SEED_A(32'h1), .SEED_B(32'h2)) dut32 (
        .clk(clk), .reset(reset), .i_start(start), .i_stop(stop), .i_hold(hold),
        .i_mode(mode), .i_num_tests(num), .o_ia(ia32), .o_ib(ib32),
        .o_valid(valid32), .o_busy(busy32), .o_done(done32), .o_count(cnt32)
    );

    stim_gen #(.WIDTH(8), .COUNT_WIDTH(32), .SEED_A(32'h1), .SEED_B(32'h2)) dut8 (
        .clk(clk), .reset(reset), .i_start(start), .i_stop(stop), .i_hold(hold),
        .i_mode(mode), .i_num_tests(num), .o_ia(ia8), .o_ib(ib8),
        .o_valid(valid8), .o_busy(busy8), .o_done(done8), .o_count(cnt8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Reference vector k of a run for operand width w.
    task automatic model(input logic [1:0] m_in, input int k, input int w,
                         output logic [31:0] a, output logic [31:0] b);
        logic [31:0] mask, sa, sb, kk, hi;
        logic [1:0]  m;
        m    = m_in;
`ifndef STIM_GEN_CORNER_EN
        if (m == 2'b11) m = 2'b00;
`endif
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        hi   = 32'h1 << (w - 1);
        kk   = k;
        a    = 32'h0;
        b    = 32'h0;
        case (m)
            2'b00: begin
                sa = 32'h1;
                sb = 32'h2;
                for (int i = 0; i < k; i++) begin
                    sa = lstep(sa);
                    sb = lstep(sb);
                end
                a = sa & mask;
                b = sb & mask;
            end
            2'b01: begin
                a = kk & mask;
                b = (w == 32) ? 32'h0 : ((kk >> w) & mask);
            end
            2'b10: begin
                a = 32'h1 << (k % w);
                b = ~a & mask;
            end
            default: begin
                case (k % 8)
                    0: begin a = 0;    b = 0;    end
                    1: begin a = 0;    b = mask; end
                    2: begin a = mask; b = 0;    end
                    3: begin a = mask; b = mask; end
                    4: begin a = 1;    b = mask; end
                    5: begin a = mask; b = 1;    end
                    6: begin a = hi;   b = hi;   end
                    default: begin a = hi; b = mask; end
                endcase
            end
        endcase
    endtask

    task automatic push_range(input logic [1:0] m, input int lo, input int hi);
        logic [31:0] a, b;
        for (int k = lo; k <= hi; k++) begin
            model(m, k, 32, a, b);
            q32.push_back('{ia: a, ib: b, cnt: 32'(k + 1)});
            model(m, k, 8, a, b);
            q8.push_back('{ia: a, ib: b, cnt: 32'(k + 1)});
        end
    endtask

    // Advance one clock and score whatever both DUTs present.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (valid32) begin
            check("q32_nonempty_on_valid", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                check("vec32", {ia32, ib32}, {e.ia, e.ib});
                check("cnt32", 64'(cnt32), 64'(e.cnt));
            end
        end
        if (valid8) begin
            check("q8_nonempty_on_valid", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("vec8", {24'd0, ia8, 24'd0, ib8}, {e.ia, e.ib});
                check("cnt8", 64'(cnt8), 64'(e.cnt));
            end
        end
        if (done32) n_done32++;
        if (done8)  n_done8++;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] n);
        mode     = m;
        num      = n;
        start    = 1'b1;
        n_done32 = 0;
        n_done8  = 0;
        cycle();
        start    = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input logic [31:0] exp_cnt);
        int i;
        i = 0;
        while (!done32 && i < budget) begin
            cycle();
            i++;
        end
        check("done_seen", 64'(done32), 64'd1);
        check("done8_seen", 64'(done8), 64'd1);
        check("busy_in_done", 64'(busy32), 64'd0);
        check("valid_in_done", 64'(valid32), 64'd0);
        check("final_count32", 64'(cnt32), 64'(exp_cnt));
        check("final_count8", 64'(cnt8), 64'(exp_cnt));
        cycle();
        check("done_pulses32", 64'(n_done32), 64'd1);
        check("done_pulses8", 64'(n_done8), 64'd1);
        check("done_one_cycle", 64'(done32), 64'd0);
        check("count_kept", 64'(cnt32), 64'(exp_cnt));
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        hold  = 1'b0;
        mode  = 2'b00;
        num   = 32'd0;
        #1;
        check("reset_ia", 64'(ia32), 64'd0);
        check("reset_ib", 64'(ib32), 64'd0);
        check("reset_valid", 64'(valid32), 64'd0);
        check("reset_busy", 64'(busy32), 64'd0);
        check("reset_done", 64'(done32), 64'd0);
        check("reset_count", 64'(cnt32), 64'd0);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Random run of 5 vectors.
        push_range(2'b00, 0, 4);
        start_run(2'b00, 32'd5);
        check("first_valid_latency", 64'(valid32), 64'd1);
        check("busy_in_run", 64'(busy32), 64'd1);
        run_to_done(20, 32'd5);

        // Sweep of 300 vectors: WIDTH 8 wraps at k=256.
        push_range(2'b01, 0, 299);
        start_run(2'b01, 32'd300);
        run_to_done(400, 32'd300);
        check("sweep8_last_ia", 64'(ia8), 64'd43);
        check("sweep8_last_ib", 64'(ib8), 64'd1);

        // Walking-one with a 3-cycle hold; the held vector is re-presented once.
        push_range(2'b10, 0, 2);
        push_range(2'b10, 2, 2);
        push_range(2'b10, 3, 9);
        start_run(2'b10, 32'd10);
        cycle();
        cycle();
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            cycle();
            check("hold_valid_low", 64'(valid32), 64'd0);
            check("hold_count_frozen", 64'(cnt32), 64'd3);
            check("hold_ia_frozen", 64'(ia32), 64'd4);
        end
        hold = 1'b0;
        run_to_done(30, 32'd10);

        // Corner table, nine vectors (wraps to entry 0).
        push_range(2'b11, 0, 8);
        start_run(2'b11, 32'd9);
        run_to_done(20, 32'd9);

        // Free-run stopped after 100 vectors.
        push_range(2'b00, 0, 99);
        start_run(2'b00, 32'd0);
        i = 0;
        while (cnt32 != 32'd100 && i < 200) begin
            cycle();
            i++;
        end
        check("freerun_reached_100", 64'(cnt32), 64'd100);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_done", 64'(done32), 64'd1);
        check("stop_valid", 64'(valid32), 64'd0);
        check("stop_busy", 64'(busy32), 64'd0);
        check("stop_count", 64'(cnt32), 64'd100);
        cycle();
        check("stop_done_pulses", 64'(n_done32), 64'd1);
        check("stop_q32_drained", 64'(q32.size()), 64'd0);
        check("stop_q8_drained", 64'(q8.size()), 64'd0);

        // Start together with stop in IDLE stays in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        check("startstop_busy", 64'(busy32), 64'd0);
        check("startstop_valid", 64'(valid32), 64'd0);
        start = 1'b0;
        stop  = 1'b0;
        cycle();
        check("startstop_idle_busy", 64'(busy32), 64'd0);
        check("startstop_count", 64'(cnt32), 64'd100);

        // Reset at vector 3, then restart from the seeds.
        push_range(2'b00, 0, 2);
        start_run(2'b00, 32'd10);
        cycle();
        cycle();
        check("pre_reset_count", 64'(cnt32), 64'd3);
        reset = 1'b1;
        #1;
        check("midreset_ia", 64'(ia32), 64'd0);
        check("midreset_ib", 64'(ib32), 64'd0);
        check("midreset_valid", 64'(valid32), 64'd0);
        check("midreset_busy", 64'(busy32), 64'd0);
        check("midreset_count", 64'(cnt32), 64'd0);
        cycle();
        cycle();
        check("midreset_no_done", 64'(n_done32), 64'd0);
        reset = 1'b0;
        cycle();
        push_range(2'b00, 0, 2);
        start_run(2'b00, 32'd3);
        run_to_done(10, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stim_gen.md
# stim_gen

Operand stimulus generator that sits directly upstream of the DUT and the round-robin monitor. It produces one registered operand pair per cycle on `o_ia`/`o_ib`, fanned out to the DUT inputs and the monitor's `i_dut_ia`/`i_dut_ib`. Vectors come from one of four patterns and are issued for a programmable count. It reports progress and completion so a bench controller can sequence runs.

## Interface
Parameters:
- `WIDTH`, 32, operand width; legal range 8..32
- `COUNT_WIDTH`, 32, width of the test counter
- `SEED_A`, 32'h1, LFSR seed for operand A; a value of 0 is replaced by 1
- `SEED_B`, 32'h2, LFSR seed for operand B; a value of 0 is replaced by 1

Ports:
- `clk`  in  1  clock; every register is on posedge
- `reset`  in  1  asynchronous, active-high reset
- `i_start`  in  1  begin a run; sampled only in IDLE
- `i_stop`  in  1  abort the current run
- `i_hold`  in  1  pause; freezes the generator, count and outputs
- `i_mode`  in  2  pattern: 00 random, 01 sweep, 10 walking-one, 11 corner
- `i_num_tests`  in  COUNT_WIDTH  vectors per run; 0 = free-run until stop
- `o_ia`  out  WIDTH  operand A
- `o_ib`  out  WIDTH  operand B
- `o_valid`  out  1  `o_ia`/`o_ib` carry a new vector this cycle
- `o_busy`  out  1  FSM is in RUN
- `o_done`  out  1  one-cycle pulse at end of run
- `o_count`  out  COUNT_WIDTH  vectors issued in the current or last run

## Operation
- **Reset values:** FSM = IDLE. All outputs are 0. The LFSRs load their (substituted) seeds. Pattern state is cleared.
- **IDLE:**
  - `i_start`=1 and `i_stop`=0 → RUN.
  - On that edge the block latches `i_mode` and `i_num_tests`, reloads the pattern state, registers vector 0, and sets `o_count`=1.
  - `i_start` together with `i_stop`: stop wins and the FSM stays in IDLE.
- **RUN:**
  - Each edge with `i_hold`=0 registers the next vector and increments `o_count`. `o_count` wraps at 2^COUNT_WIDTH.
  - While `i_hold`=1 all outputs except `o_valid` are frozen, and `o_valid`=0.
  - Run ends → DONE when either:
    - (`o_valid`=1, `o_count`==latched count ≠0, `i_hold`=0), or
    - `i_stop`=1 at any time in RUN.
  - `i_start` is ignored while in RUN.
- **DONE:** lasts one cycle. `o_done`=1, `o_valid`=0, `o_busy`=0. `o_count` keeps its final value. Next state is IDLE.
- **Patterns** (k is the vector index within the run):
  - **Random:** per operand, 32-bit Galois LFSR, s' = (s>>1) ^ (s[0] ? 32'h80200003 : 0). Stepped once per issued vector; the operand is s[WIDTH-1:0].
  - **Sweep:** `o_ia` = k mod 2^WIDTH. `o_ib` increments each time `o_ia` wraps from all-ones to 0.
  - **Walking-one:** `o_ia` = 1<<(k mod WIDTH). `o_ib` = ~`o_ia`.
  - **Corner:** repeating 8-entry sequence, wraps after entry 7. M = all-ones, H = MSB only:
    - (0,0), (0,M), (M,0), (M,M), (1,M), (M,1), (H,H), (H,M)
- **Reset mid-run:** asynchronously returns the block to reset values. No `o_done` is produced.

## Timing
- All outputs are registered.
- Latency is 1 cycle from `i_start` sampled high to the first `o_valid`=1.
- When `i_hold` is low, `o_valid` stays continuously high during RUN, one vector per cycle. This matches the monitor, which accepts a vector every cycle.
- `o_done` asserts the cycle after the last valid vector.
- `i_stop` takes effect at the next edge: `o_valid` drops and `o_done` pulses on that edge.
- `i_hold` asserted at edge N: `o_valid`=0 after edge N. The vector held from before edge N is re-presented, with `o_valid`=1, after the first edge where `i_hold`=0. It is not counted twice.

## Configuration
- **`STIM_GEN_CORNER_EN` defined:** corner mode (11) works as specified.
- **`STIM_GEN_CORNER_EN` undefined:** the corner table logic is removed. Mode 11 behaves exactly as random mode (00).

## Test plan
- **Random run:** reset, mode=00, num_tests=5, start pulse → exactly 5 cycles of `o_valid`. Vectors match the LFSR model from seeds 1 and 2. `o_done` pulses once; final `o_count`=5.
- **Sweep with small WIDTH:** WIDTH=8, mode=01, num_tests=300 → `o_ia` wraps 255→0 at k=256, where `o_ib` steps from 0 to 1. `o_done` pulses after vector 300.
- **Hold:** mode=10, num_tests=10, `i_hold` high for 3 cycles mid-run → `o_valid`=0 for those 3 cycles. The walking-one sequence resumes without a skipped or repeated position. `o_count` ends at 10.
- **Free-run and stop:** num_tests=0, mode=00, `i_stop` after 100 cycles → 100 vectors issued, `o_done` pulses, `o_busy`=0. Start and stop together in IDLE → FSM stays in IDLE.
- **Corner table:** mode=11, num_tests=9, WIDTH=32 → the 8 entries appear in order, then (0,0) again. Same stimulus with the macro undefined → output equals random mode.
- **Reset mid-run:** assert `reset` at vector 3 → outputs go to 0 immediately and no `o_done` pulses. A following start restarts from the seeds.
